// File: rtl/reg_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of two write-back sources onto the
// register file's single write port, plus a pending-write scoreboard for RAW checks.
module reg_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,

    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              chk_busy1,
    output logic              chk_busy2,

    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int               NREG    = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              prio;       // 0: A favoured on conflict, 1: B favoured
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic              a_xfer;
    logic              b_xfer;
    logic              conflict;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    // Ready is forced low during reset so nothing is accepted in a reset cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst_n) begin
            a_ready = a_valid && (!b_valid || !prio);
            b_ready = b_valid && (!a_valid || prio);
        end
    end

    assign conflict   = a_valid && b_valid;
    assign a_xfer     = a_valid && a_ready;
    assign b_xfer     = b_valid && b_ready;
    assign grant_addr = b_xfer ? b_addr : a_addr;
    assign grant_data = b_xfer ? b_data : a_data;

    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        // A reservation landing with a retiring write belongs to a later write, so set wins.
        if (rsv_en && (rsv_addr != '0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    // Register 0 is hard-wired zero and therefore never pending.
    assign chk_busy1 = (chk_addr1 != '0) && busy[chk_addr1];
    assign chk_busy2 = (chk_addr2 != '0) && busy[chk_addr2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like any other state.
            busy         <= '0;
            prio         <= 1'b0;
            conflict_cnt <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_en <= (a_xfer || b_xfer) && (grant_addr != '0);
            if (a_xfer || b_xfer) begin
                wr_addr <= grant_addr;
                wr_data <= grant_data;
            end
            busy <= busy_next;
            if (conflict) begin
                prio <= ~prio;
                if (conflict_cnt != CNT_MAX) begin
                    conflict_cnt <= conflict_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Self-checking bench for reg_wb_scheduler: directed test-plan scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/100ps
module tb_reg_wb_scheduler;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 16;
    localparam int NREG    = 32;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, a_ready, b_valid, b_ready;
    logic [ADDR_W-1:0] a_addr, b_addr, rsv_addr, chk_addr1, chk_addr2, wr_addr;
    logic [DATA_W-1:0] a_data, b_data, wr_data;
    logic              rsv_en, chk_busy1, chk_busy2, wr_en;
    logic [CNT_W-1:0]  conflict_cnt;

    always #5 clk = ~clk;

    reg_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .conflict_cnt(conflict_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: whose turn it is, which registers await a write,
    // what the write port shows this cycle, and how many conflicts were seen.
    bit                m_turn_b;
    bit                m_busy [NREG];
    int                m_cnt;
    bit                m_wr_en;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [DATA_W-1:0] m_wr_data;
    bit                m_ga, m_gb;
    bit                cmp_en = 1'b0;
    int                m_w, c_w;

    // 0: nobody granted, 1: A granted, 2: B granted
    function automatic int winner();
        if (!rst_n) return 0;
        if (a_valid && b_valid) return m_turn_b ? 2 : 1;
        if (a_valid) return 1;
        if (b_valid) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_turn_b  = 1'b0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_cnt     = 0;
            m_wr_en   = 1'b0;
            m_wr_addr = '0;
            m_wr_data = '0;
            m_ga      = 1'b0;
            m_gb      = 1'b0;
        end else begin
            m_w  = winner();
            m_ga = (m_w == 1);
            m_gb = (m_w == 2);
            if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
            m_wr_en = 1'b0;
            if (m_ga) begin
                m_wr_addr = a_addr; m_wr_data = a_data; m_wr_en = (a_addr != 0);
            end else if (m_gb) begin
                m_wr_addr = b_addr; m_wr_data = b_data; m_wr_en = (b_addr != 0);
            end
            if (a_valid && b_valid) begin
                m_turn_b = !m_turn_b;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            c_w = winner();
            check("a_ready",      a_ready,      32'(c_w == 1));
            check("b_ready",      b_ready,      32'(c_w == 2));
            check("wr_en",        wr_en,        32'(m_wr_en));
            check("wr_addr",      wr_addr,      32'(m_wr_addr));
            check("wr_data",      wr_data,      m_wr_data);
            check("conflict_cnt", conflict_cnt, 32'(m_cnt));
            check("chk_busy1",    chk_busy1,    32'(chk_addr1 != 0 && m_busy[chk_addr1]));
            check("chk_busy2",    chk_busy2,    32'(chk_addr2 != 0 && m_busy[chk_addr2]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit                exp_ga [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [ADDR_W-1:0] exp_wa [4] = '{5'd1, 5'd2, 5'd1, 5'd2};

        rst_n = 1'b0;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1111_0001;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2222_0002;
        rsv_en = 1'b0; rsv_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
        tick();
        cmp_en = 1'b1;

        // Reset held with both sources requesting.
        for (int r = 0; r < 2; r++) begin
            check("rst_a_ready", a_ready, 0);
            check("rst_b_ready", b_ready, 0);
            check("rst_wr_en", wr_en, 0);
            check("rst_conflict_cnt", conflict_cnt, 0);
            for (int i = 0; i < NREG; i++) begin
                chk_addr1 = 5'(i);
                chk_addr2 = 5'(NREG - 1 - i);
                #0.1;
                check("rst_chk_busy1", chk_busy1, 0);
                check("rst_chk_busy2", chk_busy2, 0);
            end
            tick();
        end
        rst_n = 1'b1;
        chk_addr1 = '0;
        chk_addr2 = '0;

        // Round-robin: four conflict cycles grant A, B, A, B.
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin a_valid = 1'b0; b_valid = 1'b0; end
            #3;
            if (k < 4) begin
                check("rr_a_ready", a_ready, 32'(exp_ga[k]));
                check("rr_b_ready", b_ready, 32'(!exp_ga[k]));
            end
            if (k > 0) begin
                check("rr_wr_en", wr_en, 1);
                check("rr_wr_addr", wr_addr, 32'(exp_wa[k-1]));
            end
            if (k == 4) check("rr_conflict_cnt", conflict_cnt, 4);
            tick();
        end

        // Single source write.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        #3 check("single_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        #3;
        check("single_wr_en", wr_en, 1);
        check("single_wr_addr", wr_addr, 5);
        check("single_wr_data", wr_data, 32'hDEAD_BEEF);
        tick();
        #3 check("single_wr_en_off", wr_en, 0);
        tick();

        // Scoreboard timeline on register 7.
        chk_addr1 = 5'd7; rsv_en = 1'b1; rsv_addr = 5'd7;
        #3 check("sb_busy_rsv_cycle", chk_busy1, 0);
        tick();
        rsv_en = 1'b0;
        repeat (2) begin
            #3 check("sb_busy_pending", chk_busy1, 1);
            tick();
        end
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0707_0707;
        #3;
        check("sb_b_ready", b_ready, 1);
        check("sb_busy_grant", chk_busy1, 1);
        tick();
        b_valid = 1'b0;
        #3;
        check("sb_busy_write", chk_busy1, 1);
        check("sb_wr_en", wr_en, 1);
        tick();
        #3 check("sb_busy_cleared", chk_busy1, 0);
        tick();

        // Same-cycle set and clear of register 7: set wins.
        rsv_en = 1'b1; b_valid = 1'b1; b_data = 32'h7777_0001;
        tick();
        b_valid = 1'b0;
        #3 check("sb_sc_wr_en", wr_en, 1);
        tick();
        rsv_en = 1'b0;
        #3 check("sb_set_wins", chk_busy1, 1);
        tick();
        b_valid = 1'b1; b_data = 32'h7777_0002;
        tick();
        b_valid = 1'b0;
        tick();
        #3 check("sb_busy_final_clear", chk_busy1, 0);
        tick();

        // Register 0: write accepted but dropped, reservation ignored.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0BAD_0000;
        rsv_en = 1'b1; rsv_addr = 5'd0; chk_addr1 = 5'd0;
        #3 check("r0_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0; rsv_en = 1'b0;
        #3;
        check("r0_wr_en", wr_en, 0);
        check("r0_chk_busy", chk_busy1, 0);
        tick();

        // Randomized traffic with the hold-until-ready protocol and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if (!a_valid || m_ga) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_addr  = 5'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (!b_valid || m_gb) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_addr  = 5'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            rsv_en    = ($urandom_range(0, 3) == 0);
            rsv_addr  = 5'($urandom_range(0, 7));
            chk_addr1 = 5'($urandom_range(0, 7));
            chk_addr2 = 5'($urandom_range(0, NREG - 1));
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; rsv_en = 1'b0;
        tick();

        // Reset mid-operation: reservation lost, B dropped, priority back to A.
        rsv_en = 1'b1; rsv_addr = 5'd9; chk_addr1 = 5'd9;
        tick();
        rsv_en = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd10; b_addr = 5'd11;
        #3 check("mid_rst_busy_before", chk_busy1, 1);
        tick();
        if (!m_turn_b) tick();
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h9999_9999;
        rst_n = 1'b0;
        #3 check("mid_rst_b_ready", b_ready, 0);
        tick();
        rst_n = 1'b1; b_valid = 1'b0;
        #3;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_busy_lost", chk_busy1, 0);
        a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd3; b_addr = 5'd4;
        #0.1 check("mid_rst_prio_a", a_ready, 1);
        tick();

        // Saturation of the conflict counter.
        repeat (65540) tick();
        #3 check("sat_conflict_cnt", conflict_cnt, 32'h0000_FFFF);
        tick();
        #3 check("sat_conflict_hold", conflict_cnt, 32'h0000_FFFF);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
